// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, frame constants and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_IDLE_LVL  = 1'b1;

  // Rounded-to-nearest clocks per bit.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; dout is the combinational head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty derive from the registered count, never from pointer equality.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by MMIO byte pushes.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     CLK100MHZ,
  input  logic                     ck_rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     uart_rxd_out
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK100MHZ),
    .rst_n (ck_rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign tick = (cnt_q == DIV_LAST);
  assign busy = (state_q != IDLE) || !fifo_empty;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      // A dropped push in the same cycle as clr_ovf keeps the flag set.
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    pop          = 1'b0;
    uart_rxd_out = UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
          state_d = START;
        end
      end
      START: begin
        uart_rxd_out = 1'b0;
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        uart_rxd_out = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        uart_rxd_out = par_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        uart_rxd_out = UART_IDLE_LVL;
        // Reload on the final stop cycle so queued frames run back to back.
        if (tick) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at DIV=10, DEPTH=4.
module tb_uart_tx_fifo;

  localparam int unsigned DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk;
  logic       ck_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [2:0] count;
  logic       busy;
  logic       overflow;
  logic       clr_ovf;
  logic       uart_rxd_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_tx_fifo #(
    .CLK_HZ (1000000),
    .BAUD   (100000),
    .DEPTH  (4)
  ) dut (
    .CLK100MHZ    (clk),
    .ck_rst       (ck_rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .uart_rxd_out (uart_rxd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line levels of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  // Called in frame cycle 'skip'; returns in the first cycle after the frame.
  task automatic run_frame(input logic [7:0] b, input int unsigned skip, input string tag);
    logic [10:0] fb;
    logic [10:0] smp;
    int unsigned bad;
    fb  = frame_bits(b);
    smp = '0;
    bad = 0;
    for (int unsigned c = skip; c < FRAME_BITS * DIV; c++) begin
      if (uart_rxd_out !== fb[c / DIV] || busy !== 1'b1) bad++;
      if (c % DIV == DIV - 1) smp[c / DIV] = uart_rxd_out;
      tick();
    end
    check({tag, "_bits"}, 32'(smp), 32'(fb));
    check({tag, "_wave"}, bad, 0);
  endtask

  task automatic idle_for(input int unsigned n, input string tag);
    int unsigned bad;
    bad = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (uart_rxd_out !== 1'b1 || count !== 3'd0 || busy !== 1'b0) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] ovf_bytes [6];
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clk = 1'b0; ck_rst = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check("rst_line", 32'(uart_rxd_out), 1);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    ck_rst = 1'b1;
    idle_for(50, "idle_50");

    // Single byte 0xA5
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("a5_count_n1", 32'(count), 1);
    check("a5_busy_n1", 32'(busy), 1);
    check("a5_line_n1", 32'(uart_rxd_out), 1);
    tick();
    check("a5_count_n2", 32'(count), 0);
    run_frame(8'hA5, 0, "a5");
    check("a5_busy_end", 32'(busy), 0);
    check("a5_line_end", 32'(uart_rxd_out), 1);

    // Back-to-back 0x00, 0xFF
    wr_en = 1'b1; wr_data = 8'h00;
    tick();
    wr_data = 8'hFF;
    check("b2b_count_n1", 32'(count), 1);
    tick();
    wr_en = 1'b0;
    check("b2b_count_n2", 32'(count), 1);
    run_frame(8'h00, 0, "b2b_00");
    run_frame(8'hFF, 0, "b2b_ff");
    check("b2b_busy_end", 32'(busy), 0);

    // Overflow: six pushes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = ovf_bytes[i];
      if (i == 5) begin
        check("ovf_full", 32'(full), 1);
        check("ovf_count4", 32'(count), 4);
        check("ovf_pre", 32'(overflow), 0);
      end
      tick();
    end
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count_hold", 32'(count), 4);
    wr_data = 8'h77; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    tick();
    clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    run_frame(8'h11, 6, "ovf_f1");
    run_frame(8'h22, 0, "ovf_f2");
    run_frame(8'h33, 0, "ovf_f3");
    run_frame(8'h44, 0, "ovf_f4");
    run_frame(8'h55, 0, "ovf_f5");
    idle_for(20, "ovf_idle_after");

    // Reset during data bit 3 of 0x50 with two bytes still queued
    wr_en = 1'b1; wr_data = 8'h50;
    tick();
    wr_data = 8'h3C;
    tick();
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    repeat (42) tick();
    check("mid_pre_line", 32'(uart_rxd_out), 0);
    check("mid_pre_count", 32'(count), 2);
    #2;
    ck_rst = 1'b0;
    #1;
    check("mid_rst_line", 32'(uart_rxd_out), 1);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (3) tick();
    ck_rst = 1'b1;
    idle_for(200, "mid_idle_after");

`ifdef UART_TX_PARITY_EN
    wr_en = 1'b1; wr_data = 8'h07;
    tick();
    wr_en = 1'b0;
    tick();
    run_frame(8'h07, 0, "par_07");
    check("par_07_busy_end", 32'(busy), 0);
    wr_en = 1'b1; wr_data = 8'h03;
    tick();
    wr_en = 1'b0;
    tick();
    run_frame(8'h03, 0, "par_03");
    check("par_03_busy_end", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
